// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: operand read/forward, branch resolve, EX handshake
//
// Optional feature macro: ID_FORWARD_EN
//   defined   : EX/MEM/WB results are forwarded into ID and only load-use hazards stall.
//   undefined : operands come from the register file only, and any RAW hazard on an
//               EX or MEM destination stalls (WB is excluded since the RF writes first-half).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_to_id_valid, if_to_id_bus  {pc, inst} from fetch
//   id_allow_in                   ID can accept this cycle
//   id_to_if_bus                  {branch_taken, branch_target, branch_taken_cancel}
//   ex_allow_in                   EX can accept
//   id_to_ex_valid, id_to_ex_bus  {pc, inst, imm, src1, src2, rd, rf_we, is_load, is_store, illegal}
//   rf_raddr1/2, rf_rdata1/2      register-file read port, same-cycle data
//   {ex,mem,wb}_fwd_we/dest/data  downstream results
//   ex_is_load                    EX holds a load whose data is not ready
//   system_flush                  trap/mret flush

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_BASE
`define MEM_BASE 32'h8000_0000
`endif

module id_stage #(
    parameter int PC_W = `PC_WIDTH,
    parameter int XLEN = `XLEN,
    parameter logic [PC_W-1:0] IMEM_BASE = `MEM_BASE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           if_to_id_valid,
    input  logic [PC_W+32-1:0]             if_to_id_bus,
    output logic                           id_allow_in,
    output logic [PC_W+2-1:0]              id_to_if_bus,
    input  logic                           ex_allow_in,
    output logic                           id_to_ex_valid,
    output logic [PC_W+64+2*XLEN+9-1:0]    id_to_ex_bus,
    output logic [4:0]                     rf_raddr1,
    output logic [4:0]                     rf_raddr2,
    input  logic [XLEN-1:0]                rf_rdata1,
    input  logic [XLEN-1:0]                rf_rdata2,
    input  logic                           ex_fwd_we,
    input  logic                           mem_fwd_we,
    input  logic                           wb_fwd_we,
    input  logic [4:0]                     ex_fwd_dest,
    input  logic [4:0]                     mem_fwd_dest,
    input  logic [4:0]                     wb_fwd_dest,
    input  logic [XLEN-1:0]                ex_fwd_data,
    input  logic [XLEN-1:0]                mem_fwd_data,
    input  logic [XLEN-1:0]                wb_fwd_data,
    input  logic                           ex_is_load,
    input  logic                           system_flush
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic [31:0]     id_inst;

    logic            id_ready_go;
    logic            load_use_stall;
    logic            br_fire;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign funct3 = id_inst[14:12];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    // Pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= IMEM_BASE;
            id_inst  <= 32'h0000_0013;
        end else if (system_flush) begin
            id_valid <= 1'b0;
        end else if (id_allow_in) begin
            // A fired branch/jump means whatever fetch offers now is wrong-path.
            id_valid <= if_to_id_valid & ~br_fire;
            id_pc    <= if_to_id_bus[PC_W+32-1:32];
            id_inst  <= if_to_id_bus[31:0];
        end
    end

    assign id_ready_go    = id_valid & ~load_use_stall;
    assign id_allow_in    = ~id_valid | (id_ready_go & ex_allow_in);
    assign id_to_ex_valid = id_valid & id_ready_go & ~system_flush;

    // Decode
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_opimm, is_op, illegal;

    always_comb begin
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_opimm  = 1'b0;
        is_op     = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LUI:    is_lui    = 1'b1;
            OP_AUIPC:  is_auipc  = 1'b1;
            OP_JAL:    is_jal    = 1'b1;
            OP_JALR:   is_jalr   = 1'b1;
            OP_BRANCH: is_branch = 1'b1;
            OP_LOAD:   is_load   = 1'b1;
            OP_STORE:  is_store  = 1'b1;
            OP_OPIMM:  is_opimm  = 1'b1;
            OP_OP:     is_op     = 1'b1;
            OP_SYSTEM: ;
            default:   illegal   = 1'b1;
        endcase
    end

    logic [31:0] imm;
    always_comb begin
        imm = 32'h0;
        if (is_jalr || is_load || is_opimm || opcode == OP_SYSTEM)
            imm = {{21{id_inst[31]}}, id_inst[30:20]};
        else if (is_store)
            imm = {{21{id_inst[31]}}, id_inst[30:25], id_inst[11:7]};
        else if (is_branch)
            imm = {{20{id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
        else if (is_lui || is_auipc)
            imm = {id_inst[31:12], 12'h0};
        else if (is_jal)
            imm = {{12{id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};
    end

    logic rf_we;
    assign rf_we = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) & (rd != 5'd0);

    logic use_rs1, use_rs2;
    assign use_rs1 = ~(is_lui | is_auipc | is_jal);
    assign use_rs2 = is_branch | is_store | is_op;

    // Operand select and hazard detection
    logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ID_FORWARD_EN
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0) begin
            if (ex_fwd_we && ex_fwd_dest == rs1)        rs1_val = ex_fwd_data;
            else if (mem_fwd_we && mem_fwd_dest == rs1) rs1_val = mem_fwd_data;
            else if (wb_fwd_we && wb_fwd_dest == rs1)   rs1_val = wb_fwd_data;
            else                                        rs1_val = rf_rdata1;
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0) begin
            if (ex_fwd_we && ex_fwd_dest == rs2)        rs2_val = ex_fwd_data;
            else if (mem_fwd_we && mem_fwd_dest == rs2) rs2_val = mem_fwd_data;
            else if (wb_fwd_we && wb_fwd_dest == rs2)   rs2_val = wb_fwd_data;
            else                                        rs2_val = rf_rdata2;
        end
    end

    // Only a load in EX cannot be forwarded yet.
    assign load_use_stall = id_valid & ex_fwd_we & ex_is_load & (ex_fwd_dest != 5'd0) &
                            ((use_rs1 & (ex_fwd_dest == rs1)) | (use_rs2 & (ex_fwd_dest == rs2)));
`else
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_rdata1;
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_rdata2;

    logic raw1, raw2;
    assign raw1 = (rs1 != 5'd0) & ((ex_fwd_we & (ex_fwd_dest == rs1)) | (mem_fwd_we & (mem_fwd_dest == rs1)));
    assign raw2 = (rs2 != 5'd0) & ((ex_fwd_we & (ex_fwd_dest == rs2)) | (mem_fwd_we & (mem_fwd_dest == rs2)));

    assign load_use_stall = id_valid & ((use_rs1 & raw1) | (use_rs2 & raw2));

    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_fwd_data, mem_fwd_data, wb_fwd_we, wb_fwd_dest, wb_fwd_data};
`endif

    // Branch resolve
    logic cmp_taken;
    always_comb begin
        cmp_taken = 1'b0;
        case (funct3)
            3'b000:  cmp_taken = (rs1_val == rs2_val);
            3'b001:  cmp_taken = (rs1_val != rs2_val);
            3'b100:  cmp_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  cmp_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  cmp_taken = (rs1_val <  rs2_val);
            3'b111:  cmp_taken = (rs1_val >= rs2_val);
            default: cmp_taken = 1'b0;
        endcase
    end

    assign br_fire = id_valid & id_ready_go & ex_allow_in & ~system_flush &
                     (is_jal | is_jalr | (is_branch & cmp_taken));

    logic [PC_W-1:0] br_target;
    always_comb begin
        if (is_jalr)
            br_target = (PC_W'(rs1_val) + PC_W'(imm)) & {{(PC_W-1){1'b1}}, 1'b0};
        else
            br_target = id_pc + PC_W'(imm);
    end

    logic redirect;
    assign redirect     = br_fire & ~rst;
    assign id_to_if_bus = {redirect, (redirect ? br_target : {PC_W{1'b0}}), redirect};

    // Outgoing operands
    logic [XLEN-1:0] src1;
    always_comb begin
        if (is_auipc || is_jal) src1 = XLEN'(id_pc);
        else if (is_lui)        src1 = '0;
        else                    src1 = rs1_val;
    end

    assign id_to_ex_bus = {id_pc, id_inst, imm, src1, rs2_val, rd, rf_we, is_load, is_store, illegal};

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed vector bench for id_stage

module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        id_allow_in;
    logic [33:0] id_to_if_bus;
    logic        ex_allow_in;
    logic        id_to_ex_valid;
    logic [168:0] id_to_ex_bus;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_fwd_we, mem_fwd_we, wb_fwd_we;
    logic [4:0]  ex_fwd_dest, mem_fwd_dest, wb_fwd_dest;
    logic [31:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
    logic        ex_is_load;
    logic        system_flush;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst),
        .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
        .id_allow_in(id_allow_in), .id_to_if_bus(id_to_if_bus),
        .ex_allow_in(ex_allow_in),
        .id_to_ex_valid(id_to_ex_valid), .id_to_ex_bus(id_to_ex_bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_fwd_we(ex_fwd_we), .mem_fwd_we(mem_fwd_we), .wb_fwd_we(wb_fwd_we),
        .ex_fwd_dest(ex_fwd_dest), .mem_fwd_dest(mem_fwd_dest), .wb_fwd_dest(wb_fwd_dest),
        .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .ex_is_load(ex_is_load), .system_flush(system_flush)
    );

    logic [31:0] b_pc, b_inst, b_imm, b_src1, b_src2;
    logic [4:0]  b_rd;
    logic        b_we, b_ld, b_st, b_ill;
    logic        br_taken, br_cancel;
    logic [31:0] br_target;

    assign {b_pc, b_inst, b_imm, b_src1, b_src2, b_rd, b_we, b_ld, b_st, b_ill} = id_to_ex_bus;
    assign {br_taken, br_target, br_cancel} = id_to_if_bus;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc, inst, rf1, rf2, imm, src1, src2;
        logic [4:0]  rd;
        logic        we, ld, st, ill, tk;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[13];

    // Latch one instruction and leave fetch idle afterwards; returns #2 after the latching edge.
    task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
        @(posedge clk); #1;
        if_to_id_valid = 1'b1;
        if_to_id_bus   = {pc, inst};
        @(posedge clk); #1;
        if_to_id_valid = 1'b0;
        #1;
    endtask

    task automatic clear_fwd();
        ex_fwd_we = 0; mem_fwd_we = 0; wb_fwd_we = 0; ex_is_load = 0;
        ex_fwd_dest = 0; mem_fwd_dest = 0; wb_fwd_dest = 0;
        ex_fwd_data = 0; mem_fwd_data = 0; wb_fwd_data = 0;
    endtask

    initial begin
        //          pc            inst          rf1           rf2           imm           src1          src2          rd  we ld st il tk tgt
        vecs[0]  = '{32'h80000000, 32'h00500093, 32'h00000011, 32'h00000022, 32'h00000005, 32'h00000000, 32'h00000022, 5'd1,  1, 0, 0, 0, 0, 32'h0};
        vecs[1]  = '{32'h80000010, 32'h00000863, 32'h00000011, 32'h00000022, 32'h00000010, 32'h00000000, 32'h00000000, 5'd16, 0, 0, 0, 0, 1, 32'h80000020};
        vecs[2]  = '{32'h80000000, 32'h12345137, 32'h00000011, 32'h00000022, 32'h12345000, 32'h00000000, 32'h00000022, 5'd2,  1, 0, 0, 0, 0, 32'h0};
        vecs[3]  = '{32'h80000000, 32'h00001197, 32'h00000011, 32'h00000022, 32'h00001000, 32'h80000000, 32'h00000000, 5'd3,  1, 0, 0, 0, 0, 32'h0};
        vecs[4]  = '{32'h80000100, 32'h008000EF, 32'h00000011, 32'h00000022, 32'h00000008, 32'h80000100, 32'h00000022, 5'd1,  1, 0, 0, 0, 1, 32'h80000108};
        vecs[5]  = '{32'h80000000, 32'h00408067, 32'h80000203, 32'h00000022, 32'h00000004, 32'h80000203, 32'h00000022, 5'd0,  0, 0, 0, 0, 1, 32'h80000206};
        vecs[6]  = '{32'h80000000, 32'hFE20AE23, 32'h00000011, 32'h00000022, 32'hFFFFFFFC, 32'h00000011, 32'h00000022, 5'd28, 0, 0, 1, 0, 0, 32'h0};
        vecs[7]  = '{32'h80000000, 32'h00812283, 32'h00000011, 32'h00000022, 32'h00000008, 32'h00000011, 32'h00000022, 5'd5,  1, 1, 0, 0, 0, 32'h0};
        vecs[8]  = '{32'h80000040, 32'hFE209CE3, 32'h00000007, 32'h00000007, 32'hFFFFFFF8, 32'h00000007, 32'h00000007, 5'd25, 0, 0, 0, 0, 0, 32'h0};
        vecs[9]  = '{32'h80000040, 32'hFE20CCE3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000001, 5'd25, 0, 0, 0, 0, 1, 32'h80000038};
        vecs[10] = '{32'h80000040, 32'hFE20ECE3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000001, 5'd25, 0, 0, 0, 0, 0, 32'h0};
        vecs[11] = '{32'h80000000, 32'h0000007F, 32'h00000011, 32'h00000022, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  0, 0, 0, 1, 0, 32'h0};
        vecs[12] = '{32'h80000000, 32'h00218233, 32'h00000011, 32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 5'd4,  1, 0, 0, 0, 0, 32'h0};

        rst = 1; if_to_id_valid = 0; if_to_id_bus = '0; ex_allow_in = 1;
        rf_rdata1 = 0; rf_rdata2 = 0; system_flush = 0;
        clear_fwd();

        // Reset state
        @(posedge clk); #1;
        chk("rst_ex_valid", {31'd0, id_to_ex_valid}, 32'd0);
        chk("rst_allow_in", {31'd0, id_allow_in}, 32'd1);
        chk("rst_taken", {31'd0, br_taken}, 32'd0);
        chk("rst_cancel", {31'd0, br_cancel}, 32'd0);
        chk("rst_target", br_target, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Decode vectors
        for (int i = 0; i < 13; i++) begin
            rf_rdata1 = vecs[i].rf1;
            rf_rdata2 = vecs[i].rf2;
            load_inst(vecs[i].pc, vecs[i].inst);
            chk($sformatf("v%0d_valid", i), {31'd0, id_to_ex_valid}, 32'd1);
            chk($sformatf("v%0d_pc", i), b_pc, vecs[i].pc);
            chk($sformatf("v%0d_inst", i), b_inst, vecs[i].inst);
            chk($sformatf("v%0d_imm", i), b_imm, vecs[i].imm);
            chk($sformatf("v%0d_src1", i), b_src1, vecs[i].src1);
            chk($sformatf("v%0d_src2", i), b_src2, vecs[i].src2);
            chk($sformatf("v%0d_rd", i), {27'd0, b_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_flags", i), {28'd0, b_we, b_ld, b_st, b_ill},
                {28'd0, vecs[i].we, vecs[i].ld, vecs[i].st, vecs[i].ill});
            chk($sformatf("v%0d_taken", i), {30'd0, br_taken, br_cancel}, {30'd0, vecs[i].tk, vecs[i].tk});
            chk($sformatf("v%0d_target", i), br_target, vecs[i].tgt);
        end

        // Taken branch squashes the instruction fetch offers in the same cycle
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        load_inst(32'h80000010, 32'h00000863);
        if_to_id_valid = 1'b1;
        if_to_id_bus   = {32'h80000014, 32'h00500093};
        #1;
        chk("sq_taken", {31'd0, br_taken}, 32'd1);
        chk("sq_target", br_target, 32'h80000020);
        chk("sq_cancel", {31'd0, br_cancel}, 32'd1);
        @(posedge clk); #1;
        if_to_id_valid = 1'b0;
        #1;
        chk("sq_ex_valid", {31'd0, id_to_ex_valid}, 32'd0);
        chk("sq_allow_in", {31'd0, id_allow_in}, 32'd1);

        // Load-use: add x4,x3,x2 behind a load to x3
        ex_fwd_we = 1; ex_is_load = 1; ex_fwd_dest = 5'd3; ex_fwd_data = 32'h55;
        load_inst(32'h80000200, 32'h00218233);
        chk("lu_raddr1", {27'd0, rf_raddr1}, 32'd3);
        chk("lu_raddr2", {27'd0, rf_raddr2}, 32'd2);
        chk("lu_allow_in", {31'd0, id_allow_in}, 32'd0);
        chk("lu_ex_valid", {31'd0, id_to_ex_valid}, 32'd0);
        @(posedge clk); #1;
        clear_fwd();
        mem_fwd_we = 1; mem_fwd_dest = 5'd3; mem_fwd_data = 32'hAA;
        #1;
`ifdef ID_FORWARD_EN
        chk("lu_ex_valid2", {31'd0, id_to_ex_valid}, 32'd1);
        chk("lu_src1", b_src1, 32'hAA);
`else
        chk("lu_ex_valid2", {31'd0, id_to_ex_valid}, 32'd0);
        @(posedge clk); #1;
        clear_fwd();
        wb_fwd_we = 1; wb_fwd_dest = 5'd3; wb_fwd_data = 32'hBB;
        #1;
        chk("lu_ex_valid3", {31'd0, id_to_ex_valid}, 32'd1);
        chk("lu_src1", b_src1, 32'h11);
`endif
        clear_fwd();

        // EX and MEM both write x5: add x6,x5,x0
        ex_fwd_we = 1; ex_fwd_dest = 5'd5; ex_fwd_data = 32'h1;
        mem_fwd_we = 1; mem_fwd_dest = 5'd5; mem_fwd_data = 32'h2;
        load_inst(32'h80000300, 32'h00028333);
`ifdef ID_FORWARD_EN
        chk("pr_ex_valid", {31'd0, id_to_ex_valid}, 32'd1);
        chk("pr_src1", b_src1, 32'h1);
`else
        chk("pr_ex_valid", {31'd0, id_to_ex_valid}, 32'd0);
        @(posedge clk); #1;
        ex_fwd_we = 0;
        #1;
        chk("pr_ex_valid2", {31'd0, id_to_ex_valid}, 32'd0);
        @(posedge clk); #1;
        mem_fwd_we = 0;
        #1;
        chk("pr_ex_valid3", {31'd0, id_to_ex_valid}, 32'd1);
        chk("pr_src1", b_src1, 32'h11);
`endif
        clear_fwd();

        // Flush while a jal sits in ID
        load_inst(32'h80000100, 32'h008000EF);
        system_flush = 1'b1;
        #1;
        chk("fl_taken", {31'd0, br_taken}, 32'd0);
        chk("fl_ex_valid", {31'd0, id_to_ex_valid}, 32'd0);
        @(posedge clk); #1;
        system_flush = 1'b0;
        #1;
        chk("fl_ex_valid2", {31'd0, id_to_ex_valid}, 32'd0);
        chk("fl_allow_in", {31'd0, id_allow_in}, 32'd1);

        // Illegal opcode held while EX backpressures
        load_inst(32'h80000400, 32'h0000007F);
        ex_allow_in    = 1'b0;
        if_to_id_valid = 1'b1;
        if_to_id_bus   = {32'h80000404, 32'h00500093};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_allow_in", c), {31'd0, id_allow_in}, 32'd0);
            chk($sformatf("hold%0d_ex_valid", c), {31'd0, id_to_ex_valid}, 32'd1);
            chk($sformatf("hold%0d_pc", c), b_pc, 32'h80000400);
            chk($sformatf("hold%0d_inst", c), b_inst, 32'h0000007F);
            chk($sformatf("hold%0d_flags", c), {28'd0, b_we, b_ld, b_st, b_ill}, 32'd1);
            @(posedge clk); #1;
        end
        ex_allow_in = 1'b1;
        if_to_id_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
